// File: rtl/fifo_flit_reader_pkg.sv
// fifo_flit_reader_pkg
//   Shared definitions for the flit read-side drain and the router write-side
//   logic: flit control-bit positions, the packet FSM state type and the
//   default downstream credit depth.
//   No ports (package).

package fifo_flit_reader_pkg;

   // Default downstream buffer depth, which is also the initial credit count.
   localparam int DEFAULT_CREDITS = 4;

   // The packet state is either waiting for a HEAD flit or forwarding body flits.
   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

   // HEAD marker sits in the most significant bit of a flit.
   function automatic int head_bit(input int width);
      return width - 1;
   endfunction

   // TAIL marker sits directly below the HEAD marker.
   function automatic int tail_bit(input int width);
      return width - 2;
   endfunction

endpackage

// File: rtl/fifo_flit_reader_credit.sv
// credit_counter
//   Up/down credit counter for credit-based flow control. It starts at the
//   downstream buffer depth, decrements when a flit is sent and increments
//   when the downstream side returns a slot. A returned credit that would push
//   the count past the buffer depth is ignored and raises a sticky error flag.
// Ports
//   clock     in   1    rising-edge clock
//   reset     in   1    asynchronous, active-high
//   inc       in   1    one credit returned by downstream
//   dec       in   1    one credit consumed by a sent flit
//   count     out  CW   current credit count
//   overflow  out  1    sticky: credit returned while already full

import fifo_flit_reader_pkg::*;

module credit_counter #(
   parameter int CREDITS = DEFAULT_CREDITS,
   parameter int CW      = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          overflow
);

   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   // A simultaneous return and consume cancel out. A return while already
   // full holds the count (the surplus credit is meaningless) and latches the
   // error until reset. The consumer never decrements at zero because a send
   // requires a nonzero count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count    <= FULL;
         overflow <= 1'b0;
      end else begin
         if (dec && !inc) begin
            count <= count - 1'b1;
         end else if (inc && !dec) begin
            if (count == FULL) begin
               overflow <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_flit_reader.sv
// fifo_flit_reader
//   Read-side drain for an SRL FIFO. Pops flits from the FIFO read port and
//   forwards them to a downstream router input buffer under credit-based flow
//   control. A packet, once started by a granted HEAD flit, is forwarded to
//   its TAIL without interleaving. Non-HEAD flits found while idle are orphans
//   and are discarded.
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high
//   fifo_data   in   WIDTH  FIFO head flit (valid when fifo_empty=0)
//   fifo_empty  in   1      FIFO empty flag
//   fifo_read   out  1      combinational pop strobe
//   enable      in   1      grant to start a new packet (HEAD flits only)
//   credit_in   in   1      downstream freed one slot
//   flit_out    out  WIDTH  registered flit to downstream
//   flit_valid  out  1      flit_out valid this cycle
//   in_packet   out  1      high between accepted HEAD and its TAIL
//   credits     out  CW     current credit count
//   drop_pulse  out  1      one cycle per discarded orphan flit
//   credit_err  out  1      sticky: credit returned while credits full

import fifo_flit_reader_pkg::*;

module fifo_flit_reader #(
   parameter int WIDTH   = 11,
   parameter int CREDITS = DEFAULT_CREDITS,
   parameter int CW      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_read,
   input  logic             enable,
   input  logic             credit_in,
   output logic [WIDTH-1:0] flit_out,
   output logic             flit_valid,
   output logic             in_packet,
   output logic [CW-1:0]    credits,
   output logic             drop_pulse,
   output logic             credit_err
);

   localparam int HEAD_IDX = head_bit(WIDTH);
   localparam int TAIL_IDX = tail_bit(WIDTH);

   state_t state;
   state_t next_state;
   logic   send;
   logic   drop;
   logic   is_head;
   logic   is_tail;

   assign is_head = fifo_data[HEAD_IDX];
   assign is_tail = fifo_data[TAIL_IDX];

   credit_counter #(
      .CREDITS (CREDITS),
      .CW      (CW)
   ) u_credit_counter (
      .clock    (clock),
      .reset    (reset),
      .inc      (credit_in),
      .dec      (send),
      .count    (credits),
      .overflow (credit_err)
   );

   // Packet state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Pop decision and next state. Inside a packet every flit is forwarded as
   // body (even a stray HEAD) and the grant is ignored so the packet always
   // drains to its TAIL. While idle only a granted HEAD may start a packet;
   // anything else at the FIFO front is an orphan and is popped without using
   // a credit. The pop strobe is suppressed while reset is held so the FIFO
   // does not advance behind the reader's back.
   always_comb begin
      next_state = state;
      send       = 1'b0;
      drop       = 1'b0;
      if (!reset && !fifo_empty) begin
         if (state == PKT) begin
            send = (credits != '0);
         end else if (is_head) begin
            send = enable && (credits != '0);
         end else begin
            drop = 1'b1;
         end
      end
      if (send) begin
         next_state = is_tail ? IDLE : PKT;
      end
   end

   assign fifo_read = send | drop;
   assign in_packet = (state == PKT);

   // Output register: a flit popped on this edge is presented next cycle.
   // flit_out keeps its last value when nothing is sent so downstream sees a
   // stable bus; only flit_valid qualifies it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flit_out   <= '0;
         flit_valid <= 1'b0;
         drop_pulse <= 1'b0;
      end else begin
         if (send) begin
            flit_out <= fifo_data;
         end
         flit_valid <= send;
         drop_pulse <= drop;
      end
   end

endmodule

// File: tb/tb_fifo_flit_reader.sv
// tb_fifo_flit_reader
//   Self-checking bench for fifo_flit_reader. A queue stands in for the FIFO,
//   a behavioural model tracks packet/credit state, a vector table covers the
//   basic packet and orphan cases, hand-written sequences cover multi-cycle
//   corners, and a randomized phase runs against the model.

module tb_fifo_flit_reader;

   localparam int WIDTH   = 11;
   localparam int CREDITS = 4;
   localparam int CW      = 4;

   localparam logic [WIDTH-1:0] HB = 11'h400;
   localparam logic [WIDTH-1:0] TB = 11'h200;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_empty;
   logic             fifo_read;
   logic             enable;
   logic             credit_in;
   logic [WIDTH-1:0] flit_out;
   logic             flit_valid;
   logic             in_packet;
   logic [CW-1:0]    credits;
   logic             drop_pulse;
   logic             credit_err;

   fifo_flit_reader #(
      .WIDTH   (WIDTH),
      .CREDITS (CREDITS),
      .CW      (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_read  (fifo_read),
      .enable     (enable),
      .credit_in  (credit_in),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .in_packet  (in_packet),
      .credits    (credits),
      .drop_pulse (drop_pulse),
      .credit_err (credit_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in FIFO contents, front at index 0.
   logic [WIDTH-1:0] fifo_q[$];

   // Behavioural reference state.
   bit               m_in_pkt;
   int               m_credits;
   bit               m_err;
   logic [WIDTH-1:0] m_flit;
   bit               m_valid;
   bit               m_drop;

   int check_count;
   int pass_count;
   int sent_count;
   int drop_count;

   typedef struct {
      bit               push;
      logic [WIDTH-1:0] flit;
      bit               en;
      bit               cin;
      bit               exp_read;
      bit               exp_valid;
      int               exp_credits;
      bit               exp_in_pkt;
      bit               exp_drop;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_in_pkt  = 0;
      m_credits = CREDITS;
      m_err     = 0;
      m_flit    = '0;
      m_valid   = 0;
      m_drop    = 0;
   endtask

   task automatic compareModel();
      checkOutput("flit_valid", 32'(flit_valid), 32'(m_valid));
      checkOutput("flit_out",   32'(flit_out),   32'(m_flit));
      checkOutput("in_packet",  32'(in_packet),  32'(m_in_pkt));
      checkOutput("credits",    32'(credits),    32'(m_credits));
      checkOutput("drop_pulse", 32'(drop_pulse), 32'(m_drop));
      checkOutput("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   // One clock cycle: present the queue front and control inputs, check the
   // pop strobe before the edge, then advance the model and compare after it.
   task automatic applyStimulus(input bit en, input bit cin);
      logic [WIDTH-1:0] f;
      bit emp, hd, tl, can_send, orphan, rd;
      @(negedge clock);
      emp = (fifo_q.size() == 0);
      f   = emp ? '0 : fifo_q[0];
      fifo_empty = emp;
      fifo_data  = f;
      enable     = en;
      credit_in  = cin;
      #1;
      hd       = f[WIDTH-1];
      tl       = f[WIDTH-2];
      can_send = !emp && (m_credits > 0) && (m_in_pkt || (hd && en));
      orphan   = !emp && !m_in_pkt && !hd;
      checkOutput("fifo_read", 32'(fifo_read), 32'(can_send || orphan));
      rd = fifo_read;
      @(posedge clock);
      #1;
      if (rd && !emp) void'(fifo_q.pop_front());
      m_valid = can_send;
      m_drop  = orphan;
      if (can_send) begin
         m_flit   = f;
         m_in_pkt = !tl;
      end
      if (can_send && !cin) m_credits = m_credits - 1;
      else if (cin && !can_send) begin
         if (m_credits == CREDITS) m_err = 1;
         else m_credits = m_credits + 1;
      end
      compareModel();
      if (flit_valid) sent_count++;
      if (drop_pulse) drop_count++;
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset      = 1'b1;
      enable     = 1'b0;
      credit_in  = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      fifo_q.delete();
      modelReset();
      @(negedge clock);
      reset = 1'b0;
      sent_count = 0;
      drop_count = 0;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      credit_in   = 1'b0;
      fifo_empty  = 1'b1;
      fifo_data   = '0;
      modelReset();
      #2;
      checkOutput("rst_flit_valid", 32'(flit_valid), 0);
      checkOutput("rst_credits",    32'(credits), CREDITS);
      checkOutput("rst_in_packet",  32'(in_packet), 0);
      checkOutput("rst_fifo_read",  32'(fifo_read), 0);

      // Vector table: a 3-flit packet, then an orphan body flit while idle.
      resetDut();
      vecs.push_back('{1, HB | 11'h001, 1, 0, 1, 1, 3, 1, 0});
      vecs.push_back('{1, 11'h002,      1, 0, 1, 1, 2, 1, 0});
      vecs.push_back('{1, TB | 11'h003, 1, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{0, 11'h000,      1, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{1, 11'h055,      1, 0, 1, 0, 1, 0, 1});
      vecs.push_back('{0, 11'h000,      1, 0, 0, 0, 1, 0, 0});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].push) fifo_q.push_back(vecs[i].flit);
         applyStimulus(vecs[i].en, vecs[i].cin);
         checkOutput($sformatf("vec%0d_valid", i),   32'(flit_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d_credits", i), 32'(credits),    32'(vecs[i].exp_credits));
         checkOutput($sformatf("vec%0d_in_pkt", i),  32'(in_packet),  32'(vecs[i].exp_in_pkt));
         checkOutput($sformatf("vec%0d_drop", i),    32'(drop_pulse), 32'(vecs[i].exp_drop));
      end

      // Credit exhaustion on a 6-flit packet, then resume one flit per credit.
      $display("[TB] credit stall sequence");
      resetDut();
      fifo_q.push_back(HB | 11'h010);
      for (int i = 1; i <= 4; i++) fifo_q.push_back(11'h010 + 11'(i));
      fifo_q.push_back(TB | 11'h015);
      for (int i = 0; i < 7; i++) applyStimulus(1, 0);
      checkOutput("t2_sent_before_stall", 32'(sent_count), 4);
      checkOutput("t2_credits_zero", 32'(credits), 0);
      applyStimulus(1, 1);
      applyStimulus(1, 0);
      checkOutput("t2_fifth_flit", 32'(sent_count), 5);
      applyStimulus(1, 1);
      applyStimulus(1, 0);
      checkOutput("t2_tail_flit", 32'(flit_out), 32'(TB | 11'h015));
      checkOutput("t2_idle", 32'(in_packet), 0);

      // Grant gating on HEAD, then grant dropped mid-packet.
      $display("[TB] enable gating sequence");
      resetDut();
      fifo_q.push_back(HB | 11'h020);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      checkOutput("t4_no_send_without_grant", 32'(sent_count), 0);
      applyStimulus(1, 0);
      fifo_q.push_back(11'h021);
      fifo_q.push_back(TB | 11'h022);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      checkOutput("t4_body_tail_sent", 32'(sent_count), 3);

      // Send and credit return together, then overflowing credit return.
      $display("[TB] credit collision sequence");
      resetDut();
      fifo_q.push_back(HB | 11'h030);
      fifo_q.push_back(11'h031);
      applyStimulus(1, 0);
      applyStimulus(1, 0);
      fifo_q.push_back(11'h032);
      applyStimulus(1, 1);
      checkOutput("t5_credits_hold", 32'(credits), 2);
      applyStimulus(1, 1);
      applyStimulus(1, 1);
      applyStimulus(1, 1);
      checkOutput("t5_credit_err", 32'(credit_err), 1);
      checkOutput("t5_credits_full", 32'(credits), CREDITS);

      // Asynchronous reset mid-packet; leftover body flits become orphans.
      $display("[TB] mid-packet reset sequence");
      resetDut();
      fifo_q.push_back(HB | 11'h040);
      fifo_q.push_back(11'h041);
      fifo_q.push_back(11'h042);
      fifo_q.push_back(11'h043);
      fifo_q.push_back(TB | 11'h044);
      applyStimulus(1, 0);
      applyStimulus(1, 0);
      #1;
      fifo_data  = fifo_q[0];
      fifo_empty = 1'b0;
      reset      = 1'b1;
      #1;
      modelReset();
      checkOutput("t6_async_valid",    32'(flit_valid), 0);
      checkOutput("t6_async_flit",     32'(flit_out), 0);
      checkOutput("t6_async_in_pkt",   32'(in_packet), 0);
      checkOutput("t6_async_credits",  32'(credits), CREDITS);
      checkOutput("t6_read_in_reset",  32'(fifo_read), 0);
      @(negedge clock);
      reset = 1'b0;
      drop_count = 0;
      for (int i = 0; i < 4; i++) applyStimulus(1, 0);
      checkOutput("t6_orphans_dropped", 32'(drop_count), 3);

      // Randomized traffic against the model.
      $display("[TB] random phase");
      resetDut();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) begin
            logic [WIDTH-1:0] f;
            f = WIDTH'($urandom_range(0, 511));
            f[WIDTH-1] = ($urandom_range(0, 2) == 0);
            f[WIDTH-2] = ($urandom_range(0, 2) == 0);
            fifo_q.push_back(f);
         end
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
